// File: rtl/flow_field_expander_if.sv
// Coarse-in / fine-out stream bundle for the 2x flow-field expander.
// slave is the expander's view; master is the environment driving it.
interface flow_field_expander_if #(
  parameter int MSG_W = 64
);
  logic [MSG_W-1:0] recv_msg;
  logic             recv_val;
  logic             recv_rdy;
  logic [MSG_W-1:0] send_msg;
  logic             send_val;
  logic             send_rdy;
  logic             send_eol;
  logic             send_eof;

  modport slave (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val, send_eol, send_eof
  );

  modport master (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val, send_eol, send_eof
  );
endinterface

// File: rtl/flow_field_expander.sv
// Nearest-neighbour 2x (u,v) expander: each coarse vector is doubled and emitted as a 2x2
// fine block, horizontal copy from a hold register, vertical copy from a one-line buffer.

module ffe_lane_scale #(
  parameter int VEC_W = 32
) (
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] dout
);
  // x2 with two's-complement wrap: the sign bit simply falls off the top
  assign dout = din << 1;
endmodule

module flow_field_expander #(
  parameter int COARSE_W  = 32,
  parameter int COARSE_H  = 32,
  parameter int NUM_LANES = 2,
  parameter int VEC_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  flow_field_expander_if.slave ffi
);
  localparam int CXW = (COARSE_W > 1) ? $clog2(COARSE_W) : 1;
  localparam int CYW = (COARSE_H > 1) ? $clog2(COARSE_H) : 1;

  typedef logic [NUM_LANES-1:0][VEC_W-1:0] vec_t;
  typedef enum logic {ROW_A, ROW_B} state_e;

  vec_t in_vec, sc_vec;
  assign in_vec = ffi.recv_msg;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ffe_lane_scale #(.VEC_W(VEC_W)) u_scale (.din(in_vec[l]), .dout(sc_vec[l]));
  end

  state_e         state_q, state_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic           phase_q, phase_d;
  vec_t           hold_q, hold_d;
  vec_t           msg_q, msg_d;
  logic           val_q, val_d;
  logic           eol_q, eol_d;
  logic           eof_q, eof_d;
  vec_t           line_q [COARSE_W];

  logic load, recv_rdy, xfer, last_x, last_y, line_we;

  always_comb begin
    load     = !val_q | ffi.send_rdy;
    recv_rdy = reset & load & (state_q == ROW_A) & !phase_q;
    xfer     = ffi.recv_val & recv_rdy;
    last_x   = (cx_q == CXW'(COARSE_W - 1));
    last_y   = (cy_q == CYW'(COARSE_H - 1));

    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    msg_d   = msg_q;
    val_d   = val_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    line_we = 1'b0;

    if (load) begin
      case (state_q)
        ROW_A: begin
          if (!phase_q) begin
            if (xfer) begin
              line_we = 1'b1;
              hold_d  = sc_vec;
              msg_d   = sc_vec;
              val_d   = 1'b1;
              eol_d   = 1'b0;
              eof_d   = 1'b0;
              phase_d = 1'b1;
            end else begin
              // bubble: nothing arrived, keep position
              val_d = 1'b0;
              eol_d = 1'b0;
              eof_d = 1'b0;
            end
          end else begin
            msg_d   = hold_q;
            val_d   = 1'b1;
            eol_d   = last_x;
            eof_d   = 1'b0;
            phase_d = 1'b0;
            if (last_x) begin
              cx_d    = '0;
              state_d = ROW_B;
            end else begin
              cx_d = cx_q + CXW'(1);
            end
          end
        end
        ROW_B: begin
          msg_d   = line_q[cx_q];
          val_d   = 1'b1;
          eol_d   = 1'b0;
          eof_d   = 1'b0;
          phase_d = !phase_q;
          if (phase_q) begin
            eol_d = last_x;
            if (last_x) begin
              cx_d    = '0;
              state_d = ROW_A;
              eof_d   = last_y;
              cy_d    = last_y ? '0 : cy_q + CYW'(1);
            end else begin
              cx_d = cx_q + CXW'(1);
            end
          end
        end
        default: state_d = ROW_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ROW_A;
      cx_q    <= '0;
      cy_q    <= '0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      msg_q   <= '0;
      val_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      msg_q   <= msg_d;
      val_q   <= val_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  // line buffer is never cleared; ROW_B only reads what the preceding ROW_A wrote
  always_ff @(posedge clk) begin
    if (line_we) line_q[cx_q] <= sc_vec;
  end

  assign ffi.recv_rdy = recv_rdy;
  assign ffi.send_msg = msg_q;
  assign ffi.send_val = val_q;
  assign ffi.send_eol = eol_q;
  assign ffi.send_eof = eof_q;
endmodule
